// File: rtl/sign_narrow_packer.sv
// ============================================================================
// Module      : sign_narrow_packer
// Description : Narrows signed 32-bit words to 16 bits and packs two halves
//               per output word {second, first}. Out-of-range inputs are
//               flagged and counted. A held unpaired half can be flushed
//               out as {16'h0000, half}.
//               Optional build macro SIGN_NARROW_SATURATE_EN: when defined,
//               out-of-range inputs saturate to 16'h7FFF/16'h8000; when not
//               defined they are truncated to data_i[15:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_narrow_packer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      data_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             flush_i,
   output logic [31:0]      data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             ovf_o,
   output logic [CNT_W-1:0] ovf_cnt_o
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] held_q;
   logic        held_ovf_q;

   logic        accept;
   logic        in_range;
   logic        in_ovf;
   logic [15:0] narrowed;
   logic        pair_done;
   logic        flush_go;

   // Handshake and range classification of the incoming word
   always_comb begin
      ready_o   = !valid_o || ready_i;
      accept    = valid_i && ready_o;
      // In range when the top 17 bits are all copies of the sign bit
      in_range  = (&data_i[31:15]) || (~|data_i[31:15]);
      in_ovf    = !in_range;
      pair_done = accept && (state_q == HALF);
      flush_go  = (state_q == HALF) && flush_i && ready_o && !accept;
   end

   // Map the input to its 16-bit half
   always_comb begin
      narrowed = data_i[15:0];
`ifdef SIGN_NARROW_SATURATE_EN
      if (!in_range) begin
         narrowed = data_i[31] ? 16'h8000 : 16'h7FFF;
      end
`endif
   end

   // Next-state logic: a half is held between the first accept and pairing/flush
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = HALF;
         HALF:  if (pair_done || flush_go) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   // Held half capture on the first accept of a pair
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         held_q     <= 16'h0000;
         held_ovf_q <= 1'b0;
      end else if (accept && (state_q == EMPTY)) begin
         held_q     <= narrowed;
         held_ovf_q <= in_ovf;
      end
   end

   // Output word register: load on pair or flush, drop valid once consumed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_o  <= 32'h0;
         ovf_o   <= 1'b0;
         valid_o <= 1'b0;
      end else if (pair_done) begin
         data_o  <= {narrowed, held_q};
         ovf_o   <= held_ovf_q || in_ovf;
         valid_o <= 1'b1;
      end else if (flush_go) begin
         data_o  <= {16'h0000, held_q};
         ovf_o   <= held_ovf_q;
         valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

   // Saturating count of accepted out-of-range inputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_cnt_o <= '0;
      end else if (accept && in_ovf && !(&ovf_cnt_o)) begin
         ovf_cnt_o <= ovf_cnt_o + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sign_narrow_packer.sv
// ============================================================================
// Module      : tb_sign_narrow_packer
// Description : Directed self-checking bench for sign_narrow_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_narrow_packer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] data_i = 32'h0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        flush_i = 1'b0;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic        ovf_o;
   logic [1:0]  ovf_cnt_o;

   int checks = 0;
   int errors = 0;

   sign_narrow_packer #(.CNT_W(2)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .flush_i   (flush_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .ovf_o     (ovf_o),
      .ovf_cnt_o (ovf_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      valid_i = 1'b1;
      data_i  = d;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      checks++;
      if (valid_o !== 1'b0 || data_o !== 32'h0 || ovf_o !== 1'b0 || ovf_cnt_o !== 2'b00) begin
         errors++;
         $display("FAIL reset: valid=%b data=%h ovf=%b cnt=%0d, want 0/0/0/0", valid_o, data_o, ovf_o, ovf_cnt_o);
      end
      checks++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: ready_o=%b want 1", ready_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      ready_i = 1'b1;
      send(32'hFFFF_FFFE);
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_half: valid_o=%b want 0", valid_o);
      end
      send(32'h0000_0005);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0005_FFFE || ovf_o !== 1'b0 || ovf_cnt_o !== 2'd0) begin
         errors++;
         $display("FAIL basic_pair: valid=%b data=%h ovf=%b cnt=%0d, want 1/0005fffe/0/0", valid_o, data_o, ovf_o, ovf_cnt_o);
      end
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_consume: valid_o=%b want 0", valid_o);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
`ifdef SIGN_NARROW_SATURATE_EN
      exp = 32'h8000_7FFF;
`else
      exp = 32'h0000_2345;
`endif
      send(32'h0001_2345);
      send(32'hFFFE_0000);
      checks++;
      if (valid_o !== 1'b1 || data_o !== exp || ovf_o !== 1'b1 || ovf_cnt_o !== 2'd2) begin
         errors++;
         $display("FAIL overflow: valid=%b data=%h ovf=%b cnt=%0d, want 1/%h/1/2", valid_o, data_o, ovf_o, ovf_cnt_o, exp);
      end
      tick();
   endtask

   task automatic test_backpressure();
      ready_i = 1'b0;
      send(32'h0000_0001);
      send(32'h0000_0002);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0002_0001 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_load: valid=%b data=%h ready_o=%b, want 1/00020001/0", valid_o, data_o, ready_o);
      end
      valid_i = 1'b1;
      data_i  = 32'h0000_0007;
      tick();
      tick();
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0002_0001 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold: valid=%b data=%h ovf=%b, want 1/00020001/0", valid_o, data_o, ovf_o);
      end
      ready_i = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_consume: valid_o=%b want 0", valid_o);
      end
      send(32'h0000_0008);
      send(32'h0000_0009);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0009_0008) begin
         errors++;
         $display("FAIL bp_no_accept: valid=%b data=%h, want 1/00090008", valid_o, data_o);
      end
      tick();
   endtask

   task automatic test_flush();
      send(32'h0000_1234);
      flush_i = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0000_1234 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_emit: valid=%b data=%h ovf=%b, want 1/00001234/0", valid_o, data_o, ovf_o);
      end
      tick();
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: valid_o=%b want 0", valid_o);
      end
      flush_i = 1'b0;
      send(32'h0000_000A);
      send(32'h0000_000B);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h000B_000A) begin
         errors++;
         $display("FAIL flush_state: valid=%b data=%h, want 1/000b000a", valid_o, data_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      send(32'h0000_0055);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ovf_cnt_o !== 2'd0 || data_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_clear: valid=%b cnt=%0d data=%h, want 0/0/0", valid_o, ovf_cnt_o, data_o);
      end
      send(32'h0000_0001);
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_stale: valid_o=%b want 0", valid_o);
      end
      send(32'h0000_0002);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0002_0001) begin
         errors++;
         $display("FAIL rst_mid_pair: valid=%b data=%h, want 1/00020001", valid_o, data_o);
      end
      tick();
   endtask

   task automatic test_saturation();
      send(32'h0001_0000);
      send(32'h0001_0000);
      checks++;
      if (ovf_cnt_o !== 2'd2 || ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL sat_two: cnt=%0d ovf=%b, want 2/1", ovf_cnt_o, ovf_o);
      end
      send(32'h0001_0000);
      send(32'hFFF0_0000);
      send(32'h8000_0000);
      checks++;
      if (ovf_cnt_o !== 2'b11) begin
         errors++;
         $display("FAIL sat_cnt: cnt=%0d want 3", ovf_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
